// File: rtl/mod_sub_if.sv
// Handshake/data bundle for the 256-bit sequential modular subtractor.
interface mod_sub_if;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic         busy;
    logic         done;
    logic [255:0] mod_sub_res;

    modport master (output start, a, b, p, input busy, done, mod_sub_res);
    modport slave  (input start, a, b, p, output busy, done, mod_sub_res);
endinterface

// File: rtl/mod_sub_seq.sv
// Sequential 256-bit (a - b) mod p over four 64-bit limbs: SUB pass, optional ADD-p correction.
// Optional macro MOD_SUB_CONST_TIME_EN: always run the ADD pass (adding p or 0) for a fixed 9-cycle latency.
module mod_sub_seq (
    input  logic      clk,
    input  logic      rst_n,
    mod_sub_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SUB, ADD, DONE} state_t;

    state_t       state_reg;
    logic [1:0]   cnt_reg;
    logic         cy_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [255:0] a_reg;
    logic [255:0] b_reg;
    logic [255:0] p_reg;
    logic [255:0] res_reg;
`ifdef MOD_SUB_CONST_TIME_EN
    logic         corr_reg;
`endif

    logic [63:0] a_limb   [4];
    logic [63:0] b_limb   [4];
    logic [63:0] p_limb   [4];
    logic [63:0] res_limb [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_limb
            assign a_limb[gi]   = a_reg[gi*64 +: 64];
            assign b_limb[gi]   = b_reg[gi*64 +: 64];
            assign p_limb[gi]   = p_reg[gi*64 +: 64];
            assign res_limb[gi] = res_reg[gi*64 +: 64];
        end
    endgenerate

    logic [63:0] p_add;
    logic [64:0] sub_full;
    logic [64:0] add_full;

`ifdef MOD_SUB_CONST_TIME_EN
    // Mask instead of skipping so the ADD pass costs the same cycles either way.
    assign p_add = corr_reg ? p_limb[cnt_reg] : 64'd0;
`else
    assign p_add = p_limb[cnt_reg];
`endif

    assign sub_full = {1'b0, a_limb[cnt_reg]} - {1'b0, b_limb[cnt_reg]} - {64'd0, cy_reg};
    assign add_full = {1'b0, res_limb[cnt_reg]} + {1'b0, p_add} + {64'd0, cy_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            cy_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
            res_reg   <= '0;
`ifdef MOD_SUB_CONST_TIME_EN
            corr_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        p_reg     <= bus.p;
                        cnt_reg   <= 2'd0;
                        cy_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= SUB;
                    end
                end
                SUB: begin
                    res_reg[{cnt_reg, 6'd0} +: 64] <= sub_full[63:0];
                    cy_reg  <= sub_full[64];
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
`ifdef MOD_SUB_CONST_TIME_EN
                        corr_reg  <= sub_full[64];
                        cy_reg    <= 1'b0;
                        state_reg <= ADD;
`else
                        if (sub_full[64]) begin
                            cy_reg    <= 1'b0;
                            state_reg <= ADD;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
`endif
                    end
                end
                ADD: begin
                    // Carry out of limb 3 is dropped: arithmetic wraps mod 2^256.
                    res_reg[{cnt_reg, 6'd0} +: 64] <= add_full[63:0];
                    cy_reg  <= add_full[64];
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.mod_sub_res = res_reg;
endmodule

// File: tb/tb_mod_sub_seq.sv
// Directed self-checking bench for mod_sub_seq (honours MOD_SUB_CONST_TIME_EN for latency expectations).
module tb_mod_sub_seq;
    logic clk;
    logic rst_n;
    mod_sub_if bus ();

    mod_sub_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MOD_SUB_CONST_TIME_EN
    localparam int LAT_SHORT = 9;
`else
    localparam int LAT_SHORT = 5;
`endif
    localparam int LAT_LONG = 9;
    localparam logic [255:0] SM2 =
        256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the operands, wait (bounded) for done, check latency, result and pulse width.
    task automatic run_op(input string tag, input logic [255:0] ta, input logic [255:0] tb_v,
                          input logic [255:0] tp, input logic [255:0] exp, input int exp_lat);
        int lat;
        bus.a = ta; bus.b = tb_v; bus.p = tp; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a = '1; bus.b = '1; bus.p = '1;
        lat = 1;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
        chk({tag, "_res"}, bus.mod_sub_res, exp);
        tick();
        chk({tag, "_done_low"}, {255'd0, bus.done}, 256'd0);
        chk({tag, "_res_hold"}, bus.mod_sub_res, exp);
        $display("op %s a=%0h b=%0h p=%0h res=%0h lat=%0d", tag, ta, tb_v, tp, bus.mod_sub_res, lat);
    endtask

    initial begin
        int ndone;
        int first_done;
        int lat;
        logic [255:0] cap;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0; bus.b = '0; bus.p = '0;
        tick(); tick();
        chk("rst_busy", {255'd0, bus.busy}, 256'd0);
        chk("rst_done", {255'd0, bus.done}, 256'd0);
        chk("rst_res", bus.mod_sub_res, 256'd0);
        rst_n = 1'b1;
        tick();

        run_op("small_nocorr", 256'd10, 256'd3, 256'd23, 256'd7, LAT_SHORT);
        run_op("small_corr", 256'd3, 256'd10, 256'd23, 256'd16, LAT_LONG);
        run_op("limb_borrow", 256'd1 << 64, 256'd1, 256'd1 << 255,
               256'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, LAT_SHORT);
        run_op("sm2_0m1", 256'd0, 256'd1, SM2, SM2 - 256'd1, LAT_LONG);
        run_op("sm2_aeqb", 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
               256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, SM2, 256'd0, LAT_SHORT);

        // start pulsed while busy must be ignored, not queued
        bus.a = 256'd3; bus.b = 256'd10; bus.p = 256'd23; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", {255'd0, bus.busy}, 256'd1);
        tick();
        bus.a = 256'd0; bus.b = 256'd0; bus.p = 256'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done) begin
                ndone++;
                cap = bus.mod_sub_res;
            end
            tick();
        end
        chk("ignore_start_ndone", 256'(ndone), 256'd1);
        chk("ignore_start_res", cap, 256'd16);
        $display("op ignore_start done_pulses=%0d res=%0h", ndone, cap);

        // start held high: back-to-back ops with one IDLE cycle between
        bus.a = 256'd10; bus.b = 256'd3; bus.p = 256'd23; bus.start = 1'b1;
        tick();
        lat = 1;
        while (!bus.done && lat < 20) begin tick(); lat++; end
        chk("b2b_first_lat", 256'(lat), 256'(LAT_SHORT));
        first_done = lat;
        tick(); lat++;
        chk("b2b_idle_gap", {255'd0, bus.busy}, 256'd0);
        tick(); lat++;
        while (!bus.done && lat < 40) begin tick(); lat++; end
        bus.start = 1'b0;
        chk("b2b_second_gap", 256'(lat - first_done), 256'(LAT_SHORT + 1));
        chk("b2b_second_res", bus.mod_sub_res, 256'd7);
        $display("op back_to_back first=%0d second=%0d res=%0h", first_done, lat, bus.mod_sub_res);
        tick(); tick();
        chk("b2b_stopped", {255'd0, bus.busy}, 256'd0);

        // reset during ADD aborts with no done pulse
        bus.a = 256'd3; bus.b = 256'd10; bus.p = 256'd23; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", {255'd0, bus.busy}, 256'd0);
        chk("abort_done", {255'd0, bus.done}, 256'd0);
        chk("abort_res", bus.mod_sub_res, 256'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 256'(ndone), 256'd0);
        $display("op reset_in_add done_pulses_after=%0d", ndone);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
